// File: rtl/uram_stream_reader_if.sv
// uram_stream_reader_if: burst control, URAM read port and output stream bundle
interface uram_stream_reader_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
);
  localparam int AW = $clog2(DEPTH);
  logic start;
  logic [AW-1:0] base_addr;
  logic [AW:0] length;
  logic uram_enB;
  logic [AW-1:0] uram_addrB;
  logic [WIDTH-1:0] uram_doutB;
  logic m_valid;
  logic m_ready;
  logic [WIDTH-1:0] m_data;
  logic m_last;
  logic busy;
  logic done;
  modport master (
    input  start, base_addr, length, uram_doutB, m_ready,
    output uram_enB, uram_addrB, m_valid, m_data, m_last, busy, done
  );
  modport slave (
    output start, base_addr, length, uram_doutB, m_ready,
    input  uram_enB, uram_addrB, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/uram_stream_reader.sv
// uram_stream_reader: reads a burst of URAM words and streams them out through a 2-entry FIFO
module uram_stream_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input logic clk,
  input logic rst,
  uram_stream_reader_if.master io
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L1 = (AW+1)'(1);
  localparam logic [AW-1:0] A1 = AW'(1);
  localparam logic [AW-1:0] AMAX = AW'(DEPTH-1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0] rem_q, rem_d, len_q, len_d, beat_q, beat_d;
  logic inflight_q;
  logic [WIDTH-1:0] mem_q [2];
  logic wr_q, rd_q;
  logic [1:0] cnt_q, occ;
  logic done_q, done_d;
  logic pop, issue;
  // occupancy counts the in-flight read so the FIFO can never overflow
  assign occ = cnt_q + {1'b0, inflight_q};
  assign pop = io.m_valid & io.m_ready;
  assign issue = (state_q == READ) && ((occ - {1'b0, pop}) < 2'd2);
  assign io.m_valid = cnt_q != 2'd0;
  assign io.m_data = mem_q[rd_q];
  assign io.m_last = io.m_valid && (beat_q == len_q - L1);
  assign io.uram_enB = issue;
  assign io.uram_addrB = addr_q;
  assign io.busy = state_q != IDLE;
  assign io.done = done_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    len_d = len_q;
    beat_d = pop ? beat_q + L1 : beat_q;
    done_d = pop & io.m_last;
    case (state_q)
      IDLE: if (io.start) begin
        if (io.length != '0) begin
          state_d = READ;
          addr_d = io.base_addr;
          rem_d = io.length;
          len_d = io.length;
          beat_d = '0;
        end else done_d = 1'b1;
      end
      READ: if (issue) begin
        addr_d = (addr_q == AMAX) ? '0 : addr_q + A1;
        rem_d = rem_q - L1;
        state_d = (rem_q == L1) ? DRAIN : READ;
      end
      DRAIN: state_d = (pop & io.m_last) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      len_q <= '0;
      beat_q <= '0;
      inflight_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      len_q <= len_d;
      beat_q <= beat_d;
      done_q <= done_d;
      inflight_q <= issue;
      if (inflight_q) begin
        mem_q[wr_q] <= io.uram_doutB;
        wr_q <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= occ - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_uram_stream_reader.sv
// tb_uram_stream_reader: directed bursts checked against a queue-based behavioural model
module tb_uram_stream_reader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 512;
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {logic [WIDTH-1:0] d; logic l;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uram_stream_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  uram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .io(bus));
  logic [WIDTH-1:0] mem [DEPTH];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  beat_t exp_q[$];
  bit m_busy, exp_done;
  int rd_left, outstanding, rd_addr;
  int beat_d[$];
  int beat_c[$];
  int addr_log[$];
  int en_cnt, val_cnt, done_cnt, done_c;
  int seen [DEPTH];
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  initial for (int k = 0; k < DEPTH; k++) mem[k] = WIDTH'(k + 100);
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.uram_enB) bus.uram_doutB <= mem[bus.uram_addrB];
  // model: a burst is the list of words it must deliver; occupancy is reads issued minus beats taken
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_busy = 0;
      exp_done = 0;
      rd_left = 0;
      outstanding = 0;
      rd_addr = 0;
    end else begin
      bit pop, en, was_busy;
      beat_t b;
      was_busy = m_busy;
      pop = bus.m_valid & bus.m_ready;
      en = bus.uram_enB;
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, exp_done);
      if (bus.done) begin
        done_cnt++;
        done_c = cyc;
      end
      if (bus.m_valid) begin
        val_cnt++;
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          chk("m_data", bus.m_data, exp_q[0].d);
          chk("m_last", bus.m_last, exp_q[0].l);
        end
      end else chk("m_last_idle", bus.m_last, 0);
      chk("uram_enB", en, m_busy && rd_left > 0 && (outstanding - int'(pop)) < 2);
      if (en) begin
        chk("uram_addrB", bus.uram_addrB, rd_addr);
        en_cnt++;
        addr_log.push_back(bus.uram_addrB);
        seen[bus.uram_addrB]++;
      end
      exp_done = 0;
      if (pop) begin
        beat_d.push_back(bus.m_data);
        beat_c.push_back(cyc);
        outstanding--;
        if (exp_q.size() > 0) begin
          if (exp_q[0].l) begin
            m_busy = 0;
            exp_done = 1;
          end
          void'(exp_q.pop_front());
        end
      end
      if (en) begin
        rd_left--;
        rd_addr = (rd_addr + 1) % DEPTH;
        outstanding++;
      end
      if (!was_busy && bus.start) begin
        if (bus.length == 0) exp_done = 1;
        else begin
          for (int i = 0; i < int'(bus.length); i++) begin
            b.d = mem[(int'(bus.base_addr) + i) % DEPTH];
            b.l = (i == int'(bus.length) - 1);
            exp_q.push_back(b);
          end
          m_busy = 1;
          rd_left = bus.length;
          rd_addr = bus.base_addr;
          outstanding = 0;
        end
      end
    end
  end
  task automatic clear_logs();
    beat_d.delete();
    beat_c.delete();
    addr_log.delete();
    en_cnt = 0;
    val_cnt = 0;
    done_cnt = 0;
    done_c = -1;
    foreach (seen[i]) seen[i] = 0;
  endtask
  task automatic do_start(input int base, input int len, output int s);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = AW'(base);
    bus.length = (AW+1)'(len);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    s = cyc;
  endtask
  task automatic wait_idle(input int max);
    int i;
    for (i = 0; i < max && bus.busy; i++) @(posedge clk);
    if (bus.busy) chk("idle_timeout", 1, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_last"}, bus.m_last, 0);
    chk({tag, "_uram_enB"}, bus.uram_enB, 0);
    chk({tag, "_uram_addrB"}, bus.uram_addrB, 0);
    chk({tag, "_m_data"}, bus.m_data, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
  initial begin
    int s, n;
    bit pat [7];
    pat = '{1, 0, 0, 1, 0, 1, 1};
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
    bus.m_ready = 1'b1;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    // basic burst at full throughput
    clear_logs();
    do_start(10, 4, s);
    wait_idle(50);
    chk("t1_beats", beat_d.size(), 4);
    for (int i = 0; i < 4 && i < beat_d.size(); i++) begin
      chk("t1_data", beat_d[i], 110 + i);
      chk("t1_cycle", beat_c[i], s + 2 + i);
    end
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_reads", en_cnt, 4);
    // address wrap
    clear_logs();
    do_start(DEPTH - 2, 4, s);
    wait_idle(50);
    chk("t2_reads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("t2_addr0", addr_log[0], 510);
      chk("t2_addr1", addr_log[1], 511);
      chk("t2_addr2", addr_log[2], 0);
      chk("t2_addr3", addr_log[3], 1);
    end
    chk("t2_beats", beat_d.size(), 4);
    if (beat_d.size() == 4) begin
      chk("t2_data0", beat_d[0], 610);
      chk("t2_data2", beat_d[2], 100);
      chk("t2_data3", beat_d[3], 101);
    end
    // back-pressure pattern
    clear_logs();
    do_start(10, 4, s);
    for (int i = 0; i < 7; i++) begin
      bus.m_ready = pat[i];
      @(posedge clk);
      #1;
    end
    bus.m_ready = 1'b1;
    wait_idle(50);
    chk("t3_beats", beat_d.size(), 4);
    for (int i = 0; i < 4 && i < beat_d.size(); i++) chk("t3_data", beat_d[i], 110 + i);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_reads", en_cnt, 4);
    // zero-length request
    clear_logs();
    do_start(5, 0, s);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_reads", en_cnt, 0);
    chk("t4_valid", val_cnt, 0);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_done_cycle", done_c, s);
    // reset in the middle of a burst, then a fresh burst
    clear_logs();
    do_start(30, 8, s);
    for (n = 0; n < 100 && beat_d.size() < 2; n++) @(posedge clk);
    chk("t5_two_beats", beat_d.size(), 2);
    #1 rst = 1'b1;
    #1 chk_zero("midrst");
    #4 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_after_rst_valid", bus.m_valid, 0);
    clear_logs();
    do_start(20, 3, s);
    wait_idle(50);
    chk("t5_beats", beat_d.size(), 3);
    for (int i = 0; i < 3 && i < beat_d.size(); i++) chk("t5_data", beat_d[i], 120 + i);
    chk("t5_done_cnt", done_cnt, 1);
    // full-depth burst
    clear_logs();
    do_start(0, DEPTH, s);
    wait_idle(DEPTH + 50);
    chk("t6_beats", beat_d.size(), DEPTH);
    n = 0;
    foreach (seen[i]) if (seen[i] != 1) n++;
    chk("t6_addr_once", n, 0);
    if (beat_d.size() == DEPTH) chk("t6_last_data", beat_d[DEPTH-1], 611);
    chk("t6_done_cnt", done_cnt, 1);
    // start accepted during the done pulse
    clear_logs();
    do_start(40, 2, s);
    for (n = 0; n < 50 && !bus.done; n++) begin
      @(posedge clk);
      #1;
    end
    chk("t7_done_seen", bus.done, 1);
    bus.start = 1'b1;
    bus.base_addr = AW'(50);
    bus.length = (AW+1)'(1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("t7_busy_again", bus.busy, 1);
    wait_idle(50);
    chk("t7_beats", beat_d.size(), 3);
    if (beat_d.size() == 3) begin
      chk("t7_data0", beat_d[0], 140);
      chk("t7_data1", beat_d[1], 141);
      chk("t7_data2", beat_d[2], 150);
    end
    chk("t7_done_cnt", done_cnt, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
